// File: rtl/cpu_pkg.sv
// Shared pipeline-hazard definitions: tuse/tnew encodings, forward select codes,
// MDU latency defaults and the tracking-entry record.
package cpu_pkg;

  localparam logic [1:0] TUSE_NONE = 2'd3;

  localparam logic [1:0] TNEW_LINK = 2'd0;
  localparam logic [1:0] TNEW_ALU  = 2'd1;
  localparam logic [1:0] TNEW_LOAD = 2'd2;

  localparam logic [1:0] FWD_RF = 2'd0;
  localparam logic [1:0] FWD_EM = 2'd1;
  localparam logic [1:0] FWD_MW = 2'd2;

  localparam int MULT_CYC_DEF = 5;
  localparam int DIV_CYC_DEF  = 10;

  typedef struct packed {
    logic [4:0] dst;
    logic [1:0] tnew;
    logic       md_start;
    logic       md_div;
  } entry_t;

  // One pipeline advance: the result gets one cycle closer, never below zero.
  function automatic entry_t age_entry(entry_t e);
    entry_t r;
    r = e;
    if (e.tnew != 2'd0) r.tnew = e.tnew - 2'd1;
    return r;
  endfunction

endpackage

// File: rtl/md_busy_cnt.sv
// MDU occupancy countdown: reloads when a multiply/divide sits in E, then
// counts down to zero; busy covers the E cycle plus the countdown.
module md_busy_cnt #(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic div,
  output logic busy
);

  localparam int MAX_CYC = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
  localparam int CW      = $clog2(MAX_CYC + 1);

  logic [CW-1:0] cnt_q;

  // A reload always wins over the running count.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (start) begin
      cnt_q <= div ? CW'(DIV_CYC) : CW'(MULT_CYC);
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CW'(1);
    end
  end

  assign busy = (cnt_q != '0) | start;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: E/M/W result tracking, stall and D-stage forward selects.
// Define HAZARD_MDU_EN to enable the multiply/divide busy tracking and stall.
module hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int MULT_CYC = MULT_CYC_DEF,
  parameter int DIV_CYC  = DIV_CYC_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] d_rs,
  input  logic [4:0] d_rt,
  input  logic [1:0] d_tuse_rs,
  input  logic [1:0] d_tuse_rt,
  input  logic [4:0] d_dst,
  input  logic [1:0] d_tnew,
  input  logic       d_md_start,
  input  logic       d_md_div,
  input  logic       d_md_use,
  output logic       stall,
  output logic [1:0] fwd_rs_sel,
  output logic [1:0] fwd_rt_sel,
  output logic       md_busy
);

  entry_t e_q, m_q, w_q;
  entry_t d_ent;
  logic   md_stall;

  function automatic logic raw_hazard(entry_t e, logic [4:0] src, logic [1:0] tuse);
    return (tuse != TUSE_NONE) && (e.dst != 5'd0) && (e.dst == src) && (e.tnew > tuse);
  endfunction

  // Youngest ready producer wins; W is covered by the register-file bypass.
  function automatic logic [1:0] fwd_pick(entry_t e, entry_t m, logic [4:0] src);
    if ((e.dst != 5'd0) && (e.dst == src) && (e.tnew == 2'd0)) return FWD_EM;
    if ((m.dst != 5'd0) && (m.dst == src) && (m.tnew == 2'd0)) return FWD_MW;
    return FWD_RF;
  endfunction

  always_comb begin
    d_ent      = '0;
    d_ent.dst  = d_dst;
    d_ent.tnew = d_tnew;
`ifdef HAZARD_MDU_EN
    d_ent.md_start = d_md_start;
    d_ent.md_div   = d_md_div;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      e_q <= '0;
      m_q <= '0;
      w_q <= '0;
    end else begin
      w_q <= age_entry(m_q);
      m_q <= age_entry(e_q);
      e_q <= stall ? '0 : d_ent;
    end
  end

`ifdef HAZARD_MDU_EN
  md_busy_cnt #(
    .MULT_CYC(MULT_CYC),
    .DIV_CYC (DIV_CYC)
  ) u_md_busy_cnt (
    .clk  (clk),
    .reset(reset),
    .start(e_q.md_start),
    .div  (e_q.md_div),
    .busy (md_busy)
  );
  assign md_stall = d_md_use & md_busy;
`else
  logic unused_md;
  assign unused_md = ^{d_md_start, d_md_div, d_md_use};
  assign md_busy   = 1'b0;
  assign md_stall  = 1'b0;
`endif

  logic unused_w;
  assign unused_w = ^w_q;

  always_comb begin
    stall = md_stall
          | raw_hazard(e_q, d_rs, d_tuse_rs) | raw_hazard(m_q, d_rs, d_tuse_rs)
          | raw_hazard(e_q, d_rt, d_tuse_rt) | raw_hazard(m_q, d_rt, d_tuse_rt);
    fwd_rs_sel = fwd_pick(e_q, m_q, d_rs);
    fwd_rt_sel = fwd_pick(e_q, m_q, d_rt);
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed pipeline scenarios plus random
// traffic against a timestamp-based reference model (honours HAZARD_MDU_EN).
module tb_hazard_ctrl;

  localparam int MULT_CYC = 5;
  localparam int DIV_CYC  = 10;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] d_rs, d_rt, d_dst;
  logic [1:0] d_tuse_rs, d_tuse_rt, d_tnew;
  logic       d_md_start, d_md_div, d_md_use;
  logic       stall, md_busy;
  logic [1:0] fwd_rs_sel, fwd_rt_sel;

  hazard_ctrl #(.MULT_CYC(MULT_CYC), .DIV_CYC(DIV_CYC)) dut (
    .clk(clk), .reset(reset),
    .d_rs(d_rs), .d_rt(d_rt), .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt),
    .d_dst(d_dst), .d_tnew(d_tnew),
    .d_md_start(d_md_start), .d_md_div(d_md_div), .d_md_use(d_md_use),
    .stall(stall), .fwd_rs_sel(fwd_rs_sel), .fwd_rt_sel(fwd_rt_sel), .md_busy(md_busy)
  );

  always #5 clk = ~clk;

  // Model: each in-flight producer remembers the absolute cycle its result is ready.
  typedef struct {
    int dst;
    int ready;
    bit mds;
    bit mdd;
  } ment_t;

  ment_t me, mm;
  int    now = 0;
  int    busy_last = -1;
  int    n_cmp = 0;
  int    n_err = 0;
  bit    chk_en = 1'b0;
  logic       cs, cb;
  logic [1:0] cfr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, now);
    end
  endtask

  function automatic int tn(ment_t e);
    return (e.ready > now) ? e.ready - now : 0;
  endfunction

  function automatic bit hz(ment_t e, int r, int tu);
    return (tu != 3) && (e.dst != 0) && (e.dst == r) && (tn(e) > tu);
  endfunction

  function automatic int fw(int r);
    if (me.dst != 0 && me.dst == r && tn(me) == 0) return 1;
    if (mm.dst != 0 && mm.dst == r && tn(mm) == 0) return 2;
    return 0;
  endfunction

  function automatic bit m_busy();
`ifdef HAZARD_MDU_EN
    return me.mds || (now <= busy_last);
`else
    return 1'b0;
`endif
  endfunction

  task automatic step(input bit r, input int rs, input int rt, input int tur, input int tut,
                      input int dst, input int tnew, input bit ms, input bit md, input bit mu);
    bit exp_s, exp_b;
    int exp_fr, exp_ft;
    reset = r;
    d_rs = 5'(rs); d_rt = 5'(rt); d_tuse_rs = 2'(tur); d_tuse_rt = 2'(tut);
    d_dst = 5'(dst); d_tnew = 2'(tnew);
    d_md_start = ms; d_md_div = md; d_md_use = mu;
    @(negedge clk);
    exp_b  = m_busy();
    exp_s  = hz(me, rs, tur) || hz(mm, rs, tur) || hz(me, rt, tut) || hz(mm, rt, tut) ||
             (mu && exp_b);
    exp_fr = fw(rs);
    exp_ft = fw(rt);
    cs = stall; cfr = fwd_rs_sel; cb = md_busy;
    if (chk_en) begin
      chk("stall", stall, exp_s);
      chk("fwd_rs_sel", fwd_rs_sel, exp_fr);
      chk("fwd_rt_sel", fwd_rt_sel, exp_ft);
      chk("md_busy", md_busy, exp_b);
    end
    @(posedge clk);
    if (r) begin
      me = '{dst:0, ready:0, mds:1'b0, mdd:1'b0};
      mm = me;
      busy_last = -1;
    end else begin
`ifdef HAZARD_MDU_EN
      if (me.mds) busy_last = now + (me.mdd ? DIV_CYC : MULT_CYC);
`endif
      mm = me;
      if (exp_s) me = '{dst:0, ready:0, mds:1'b0, mdd:1'b0};
`ifdef HAZARD_MDU_EN
      else me = '{dst:dst, ready:now + 1 + tnew, mds:ms, mdd:md};
`else
      else me = '{dst:dst, ready:now + 1 + tnew, mds:1'b0, mdd:1'b0};
`endif
    end
    now++;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 3, 3, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int busy_n, stall_n, lim_hit;
    int rs, rt, tur, tut, dst, tnew;
    bit ms, md, mu, r;

    me = '{dst:0, ready:0, mds:1'b0, mdd:1'b0};
    mm = me;
    step(1, 0, 0, 3, 3, 0, 0, 0, 0, 0);
    step(1, 0, 0, 3, 3, 0, 0, 0, 0, 0);
    chk_en = 1'b1;

    idle(1);
    chk("rst_stall", cs, 0);
    chk("rst_fwd_rs", cfr, 0);
    chk("rst_md_busy", cb, 0);

    // lw $1 ; addu $2,$1,$1
    step(0, 0, 0, 3, 3, 1, 2, 0, 0, 0);
    step(0, 1, 1, 1, 1, 2, 1, 0, 0, 0);
    chk("lw_use_stall", cs, 1);
    step(0, 1, 1, 1, 1, 2, 1, 0, 0, 0);
    chk("lw_use_release", cs, 0);
    idle(2);

    // addu $3 ; beq $3
    step(0, 0, 0, 3, 3, 3, 1, 0, 0, 0);
    step(0, 3, 0, 0, 3, 0, 3, 0, 0, 0);
    chk("alu_beq_stall", cs, 1);
    step(0, 3, 0, 0, 3, 0, 3, 0, 0, 0);
    chk("alu_beq_release", cs, 0);
    chk("alu_beq_fwd", cfr, 2);
    idle(2);

    // addu $0 ; reader of $0
    step(0, 0, 0, 3, 3, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 4, 1, 0, 0, 0);
    chk("r0_stall", cs, 0);
    chk("r0_fwd", cfr, 0);
    idle(2);

    // jal ; jr $31
    step(0, 0, 0, 3, 3, 31, 0, 0, 0, 0);
    step(0, 31, 0, 0, 3, 0, 3, 0, 0, 0);
    chk("jal_jr_stall", cs, 0);
    chk("jal_jr_fwd", cfr, 1);
    idle(2);

    // reset while lw in M with dependent stalled in D
    step(0, 0, 0, 3, 3, 5, 2, 0, 0, 0);
    step(0, 5, 0, 0, 3, 6, 1, 0, 0, 0);
    chk("lw_dep_stall", cs, 1);
    step(1, 5, 0, 0, 3, 6, 1, 0, 0, 0);
    step(0, 5, 0, 0, 3, 6, 1, 0, 0, 0);
    chk("post_rst_stall", cs, 0);
    chk("post_rst_fwd", cfr, 0);
    idle(3);

    // div ; mflo held until released
    step(0, 0, 0, 3, 3, 0, 1, 1, 1, 1);
    busy_n = 0; stall_n = 0; lim_hit = 1;
    for (int i = 0; i < 30; i++) begin
      step(0, 0, 0, 3, 3, 7, 1, 0, 0, 1);
      if (cb) busy_n++;
      if (cs) stall_n++;
      else begin
        lim_hit = 0;
        break;
      end
    end
    chk("div_release_seen", lim_hit, 0);
`ifdef HAZARD_MDU_EN
    chk("div_busy_cycles", busy_n, 1 + DIV_CYC);
    chk("div_stall_cycles", stall_n, 1 + DIV_CYC);
`else
    chk("div_busy_cycles", busy_n, 0);
    chk("div_stall_cycles", stall_n, 0);
`endif
    idle(12);

    // random traffic, D held with high probability while stalled
    rs = 0; rt = 0; tur = 3; tut = 3; dst = 0; tnew = 0; ms = 0; md = 0; mu = 0;
    for (int i = 0; i < 500; i++) begin
      if (!(cs && $urandom_range(0, 9) < 7)) begin
        rs   = $urandom_range(0, 3);
        rt   = $urandom_range(0, 3);
        tur  = $urandom_range(0, 3);
        tut  = $urandom_range(0, 3);
        dst  = $urandom_range(0, 3);
        tnew = $urandom_range(0, 2);
        ms   = ($urandom_range(0, 9) == 0);
        md   = $urandom_range(0, 1);
        mu   = ms | ($urandom_range(0, 7) == 0);
      end
      r = ($urandom_range(0, 59) == 0);
      step(r, rs, rt, tur, tut, dst, tnew, ms, md, mu);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
